// File: rtl/sel_stream_serializer_pkg.sv
// Shared constants and types for the selectable-order stream serializer.
package sel_pkg;

  // Index order selectors carried by in_mode (2'b11 is reserved and behaves as forward)
  localparam logic [1:0] SEL_FWD  = 2'b00;
  localparam logic [1:0] SEL_REV  = 2'b01;
  localparam logic [1:0] SEL_BREV = 2'b10;

  // Serializer control states
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } sel_state_e;

endpackage

// File: rtl/sel_stream_serializer_idx_map.sv
// Combinational beat-counter to source-index mapper (forward, reversed, bit-reversed).
module sel_idx_map
  import sel_pkg::*;
#(
  parameter int IW = 5
) (
  input  logic [IW-1:0] cnt,
  input  logic [1:0]    mode,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] brev_s;

  // Mirror the counter bits for the FFT reorder sequence
  always_comb begin
    brev_s = '0;
    for (int b = 0; b < IW; b++) begin
      brev_s[b] = cnt[IW-1-b];
    end
  end

  // Pick the index order for the active mode; reserved code falls back to forward
  always_comb begin
    idx = cnt;
    case (mode)
      SEL_FWD:  idx = cnt;
      SEL_REV:  idx = ~cnt;
      SEL_BREV: idx = brev_s;
      default:  idx = cnt;
    endcase
  end

endmodule

// File: rtl/sel_stream_serializer.sv
// Parallel-to-serial word selector: captures N words in one handshake and
// streams them one per transfer in forward, reversed or bit-reversed order.
module sel_stream_serializer
  import sel_pkg::*;
#(
  parameter  int W  = 16,
  parameter  int N  = 32,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [1:0]      in_mode,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W-1:0]    out_data,
  output logic [IW-1:0]   out_idx,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);

  sel_state_e            state_r;
  sel_state_e            state_nxt_s;
  logic [N-1:0][W-1:0]   bank_r;
  logic [1:0]            mode_r;
  logic [IW-1:0]         cnt_r;

  logic                  send_s;
  logic                  last_s;
  logic                  xfer_s;
  logic                  in_ready_s;
  logic                  accept_s;
  logic [IW-1:0]         idx_s;

  assign send_s     = (state_r == SEND);
  assign last_s     = send_s && (cnt_r == IW'(N-1));
  assign xfer_s     = send_s && out_ready;
  // A new vector is taken when idle, or on the final beat so vectors run back to back
  assign in_ready_s = rst_n && (!send_s || (xfer_s && last_s));
  assign accept_s   = in_valid && in_ready_s;

  sel_idx_map #(
    .IW (IW)
  ) u_idx_map (
    .cnt  (cnt_r),
    .mode (mode_r),
    .idx  (idx_s)
  );

  // Outputs come straight from the held bank/counter/mode through the mapper and read mux
  assign in_ready  = in_ready_s;
  assign out_valid = send_s;
  assign busy      = send_s;
  assign out_last  = last_s;
  assign out_idx   = idx_s;
  assign out_data  = bank_r[idx_s];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: leave SEND only after the final beat with no vector waiting
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (xfer_s && last_s && !accept_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Bank, mode and beat counter: reload on accept, advance on each output transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_r <= '0;
      mode_r <= SEL_FWD;
      cnt_r  <= '0;
    end else if (accept_s) begin
      bank_r <= in_data;
      mode_r <= in_mode;
      cnt_r  <= '0;
    end else if (xfer_s) begin
      if (last_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + IW'(1);
      end
    end
  end

endmodule

// File: doc/sel_stream_serializer.md
# sel_stream_serializer

Parametrised parallel-to-serial word selector for the DSP datapath. It captures a vector of N words of W bits in one handshake and emits them one per transfer on a valid/ready stream. Three index orders are selectable per vector: forward, reversed and bit-reversed (FFT reorder). It sits between parallel register banks (twiddle/sample banks) and serial consumers such as the butterfly and MAC stages, and supports back-to-back vectors with no idle cycle.

## Interface
- W, 16, word width in bits
- N, 32, words per vector; power of two, N >= 2
- IW, $clog2(N), index width (derived, not overridden)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous and active-low
- in_data  in  N*W  word i at bits [i*W +: W]
- in_mode  in  2  order for this vector: 00 forward, 01 reversed, 10 bit-reversed, 11 reserved (treated as 00)
- in_valid  in  1  vector offered
- in_ready  out  1  vector accepted when in_valid && in_ready
- out_data  out  W  current word
- out_idx  out  IW  source index of out_data
- out_last  out  1  current word is the final word of the vector
- out_valid  out  1  word offered
- out_ready  in  1  word accepted when out_valid && out_ready
- busy  out  1  a vector is held (equal to out_valid)

## Operation
- States: IDLE, SEND.
- IDLE: out_valid=0. in_ready=1 when rst_n=1. On accept: latch in_data into bank, latch in_mode into mode_q, set cnt=0, go to SEND.
- SEND: out_valid=1. out_idx=map(cnt, mode_q). out_data=bank[out_idx]. out_last=(cnt==N-1).
- map: 00/11 -> cnt; 01 -> N-1-cnt (bitwise ~cnt); 10 -> cnt with its IW bits reversed.
- On an output transfer with out_last=0: cnt increments.
- On an output transfer with out_last=1:
  - If in_valid=1: accept the new vector in the same cycle, reload bank and mode_q, set cnt=0, stay in SEND.
  - Otherwise: go to IDLE.
- in_ready = rst_n && (state==IDLE || (out_valid && out_ready && out_last)). This is the only combinational path from out_ready to in_ready.
- Bank and mode_q change only on accept. A held vector is never disturbed by in_data, in_mode or in_valid toggling.
- out_valid never drops while SEND waits on out_ready. out_data, out_idx and out_last stay stable while stalled.
- Reserved mode 11 is not an error and has no flag.

## Timing
- Reset values (rst_n=0 at a rising edge): state IDLE, cnt 0, out_valid 0, busy 0, out_last 0, out_idx 0, out_data 0 (bank cleared), in_ready 0 while rst_n=0.
- Reset mid-vector: remaining words are dropped. The first cycle after release shows IDLE with in_ready=1.
- Latency: vector accepted at edge k -> first word valid in cycle k+1.
- Throughput with out_ready held 1: one word per cycle. N cycles per vector, zero bubbles between vectors.
- out_data, out_idx and out_last are driven from registers (bank, cnt, mode_q) through the mapper mux only. There is no combinational path from in_data to out_data.

## Structure
- Package sel_pkg holds:
  - mode constants SEL_FWD=2'b00, SEL_REV=2'b01, SEL_BREV=2'b10
  - state enum {IDLE, SEND}
- Sub-module sel_idx_map: combinational, parameter IW, inputs cnt and mode, output idx. It is reused by the FFT reorder logic.
- Top level contains the bank, the counter, the FSM and the N:1 read mux.

## Test plan
All scenarios use N=32, W=16 and word i = 16'h1000+i.
- Forward, out_ready=1: one vector, mode 00 -> 32 consecutive words 1000..101F. out_idx 0..31. out_last only on 101F. Then IDLE with in_ready=1.
- Reversed: mode 01 -> first word 101F (idx 31), last word 1000 (idx 0).
- Bit-reversed, N=8: sequence idx 0,4,2,6,1,5,3,7. Mode 11 at N=32 produces the forward order.
- Backpressure: out_ready pattern 1,0,0,1 repeating -> no word lost or duplicated; out_data stable during stalls; in_data changes while held have no effect.
- Back-to-back: second vector (16'h2000+i, mode 01) offered during the last beat -> in_ready=1 on that beat; next cycle out_data=201F with no gap.
- Reset at word 10 -> out_valid=0 after the reset edge; a new vector afterwards starts at idx 0.
